// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
//
// Arbitrates ownership of one 4-digit seven-segment display among up to four
// requesters. Requester 0 has absolute priority. The other requesters share the
// display round-robin. An owner keeps the display for a minimum hold time before
// a waiting requester may take it, and a blanking gap separates two owners.
//
// Ports
//   clock_100Mhz : system clock, rising edge
//   reset        : asynchronous, active-high
//   req          : per-requester level request, held while the display is wanted
//   value        : packed 16-bit binary values, requester i at [16*i+15:16*i]
//   grant        : one-hot (or zero) ownership, registered
//   owner        : index of the current or pending owner
//   disp_value   : value to show, clamped to 0..9999, registered
//   disp_blank   : 1 = all anodes off, registered
//   sat          : 1 when the owner's raw value exceeded 9999 and was clamped
// -----------------------------------------------------------------------------
module seg_display_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int TICK_DIV    = 100000,
    parameter int MIN_HOLD_MS = 500,
    parameter int BLANK_MS    = 20
) (
    input  logic                   clock_100Mhz,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  value,
    output logic [NUM_REQ-1:0]     grant,
    output logic [1:0]             owner,
    output logic [15:0]            disp_value,
    output logic                   disp_blank,
    output logic                   sat
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLANK_MS > 0) ? $clog2(BLANK_MS + 1) : 1;
    localparam int HW = (MIN_HOLD_MS > 0) ? $clog2(MIN_HOLD_MS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_OWNED = 2'd2
    } state_t;

    // Winner: requester 0 if asserted, otherwise the first asserted ordinary
    // requester scanning upward from last+1 with wrap-around.
    function automatic logic [1:0] f_winner(input logic [NUM_REQ-1:0] rq,
                                            input logic [1:0]         last);
        logic [3:0] rq4;
        logic       found;
        logic [1:0] win;
        int         c;
        rq4   = 4'(rq);
        found = 1'b0;
        win   = last;
        if (rq4[0]) begin
            win   = 2'd0;
            found = 1'b1;
        end
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (int'(last) + k) % NUM_REQ;
            if (!found && (c != 0) && rq4[c[1:0]]) begin
                win   = c[1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [1:0] idx);
        logic [3:0] t;
        t = 4'b0001 << idx;
        return t[NUM_REQ-1:0];
    endfunction

    function automatic logic [15:0] f_sat(input logic [15:0] v);
        return (v > 16'd9999) ? 16'd9999 : v;
    endfunction

    state_t            r_state;
    logic [1:0]        r_owner;
    logic [1:0]        r_last_owner;
    logic [TW-1:0]     r_tick_cnt;
    logic [BW-1:0]     r_blank_cnt;
    logic [HW-1:0]     r_hold_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic [15:0]       r_disp_value;
    logic              r_disp_blank;
    logic              r_sat;

    logic              w_tick;
    logic [3:0]        w_req4;
    logic              w_req_own;
    logic [NUM_REQ-1:0] w_req_excl;
    logic              w_others;
    logic [1:0]        w_win;
    logic [1:0]        w_win_excl;
    logic [63:0]       w_val_pad;
    logic [15:0]       w_val_nxt;

    state_t            w_state_nxt;
    logic [1:0]        w_owner_nxt;
    logic [1:0]        w_last_nxt;
    logic [BW-1:0]     w_blank_nxt;
    logic [HW-1:0]     w_hold_nxt;

    assign w_tick     = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_req4     = 4'(req);
    assign w_req_own  = w_req4[r_owner];
    assign w_req_excl = req & ~f_onehot(r_owner);
    assign w_others   = |w_req_excl;
    assign w_win      = f_winner(req, r_last_owner);
    // Rotation starts after the current owner, so masking it out only matters
    // when the owner is requester 0.
    assign w_win_excl = f_winner(w_req_excl, r_last_owner);
    assign w_val_pad  = 64'(value);
    assign w_val_nxt  = w_val_pad[{w_owner_nxt, 4'b0000} +: 16];

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        w_blank_nxt = r_blank_cnt;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_owner_nxt = w_win;
                    w_blank_nxt = '0;
                    w_state_nxt = S_BLANK;
                end
            end
            S_BLANK: begin
                if (w_tick && (r_blank_cnt != BW'(BLANK_MS)))
                    w_blank_nxt = r_blank_cnt + 1'b1;
                if (!w_req_own) begin
                    w_state_nxt = S_IDLE;
                end else if (req[0] && (r_owner != 2'd0)) begin
                    // Requester 0 arrived during the gap: it takes over and
                    // must wait out a full gap of its own.
                    w_owner_nxt = 2'd0;
                    w_blank_nxt = '0;
                end else if (r_blank_cnt == BW'(BLANK_MS)) begin
                    w_state_nxt = S_OWNED;
                    w_hold_nxt  = '0;
                    w_last_nxt  = r_owner;
                end
            end
            S_OWNED: begin
                if (w_tick && (r_hold_cnt != HW'(MIN_HOLD_MS)))
                    w_hold_nxt = r_hold_cnt + 1'b1;
                if (!w_req_own) begin
                    if (|req) begin
                        w_owner_nxt = w_win;
                        w_blank_nxt = '0;
                        w_state_nxt = S_BLANK;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (req[0] && (r_owner != 2'd0)) begin
                    w_owner_nxt = 2'd0;
                    w_blank_nxt = '0;
                    w_state_nxt = S_BLANK;
                end else if (w_others && (r_hold_cnt == HW'(MIN_HOLD_MS))) begin
                    w_owner_nxt = w_win_excl;
                    w_blank_nxt = '0;
                    w_state_nxt = S_BLANK;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are loaded from the next state so that grant, blanking and the
    // displayed value change on the same edge as the state itself.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 2'd0;
            r_last_owner <= 2'(NUM_REQ - 1);
            r_tick_cnt   <= '0;
            r_blank_cnt  <= '0;
            r_hold_cnt   <= '0;
            r_grant      <= '0;
            r_disp_value <= 16'd0;
            r_disp_blank <= 1'b1;
            r_sat        <= 1'b0;
        end else begin
            r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_blank_cnt  <= w_blank_nxt;
            r_hold_cnt   <= w_hold_nxt;
            if (w_state_nxt == S_OWNED) begin
                r_grant      <= f_onehot(w_owner_nxt);
                r_disp_blank <= 1'b0;
                r_disp_value <= f_sat(w_val_nxt);
                r_sat        <= (w_val_nxt > 16'd9999);
            end else begin
                r_grant      <= '0;
                r_disp_blank <= 1'b1;
                r_disp_value <= 16'd0;
                r_sat        <= 1'b0;
            end
        end
    end

    assign grant      = r_grant;
    assign owner      = r_owner;
    assign disp_value = r_disp_value;
    assign disp_blank = r_disp_blank;
    assign sat        = r_sat;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_display_arbiter
//
// Directed scenarios followed by a randomized request/value phase for
// seg_display_arbiter. A behavioural model of the arbitration rules predicts
// grant, owner, disp_value, disp_blank and sat after every clock edge.
// -----------------------------------------------------------------------------
module tb_seg_display_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int TICK_DIV    = 4;
    localparam int MIN_HOLD_MS = 3;
    localparam int BLANK_MS    = 2;

    localparam int M_IDLE  = 0;
    localparam int M_BLANK = 1;
    localparam int M_OWNED = 2;

    logic                  clock_100Mhz = 1'b0;
    logic                  reset        = 1'b1;
    logic [NUM_REQ-1:0]    req          = '0;
    logic [16*NUM_REQ-1:0] value        = '0;
    logic [NUM_REQ-1:0]    grant;
    logic [1:0]            owner;
    logic [15:0]           disp_value;
    logic                  disp_blank;
    logic                  sat;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_mode, m_owner, m_last, m_bcnt, m_hcnt, m_edges;
    logic [2:0]  e_grant;
    logic        e_blank, e_sat;
    logic [15:0] e_disp;

    seg_display_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .TICK_DIV   (TICK_DIV),
        .MIN_HOLD_MS(MIN_HOLD_MS),
        .BLANK_MS   (BLANK_MS)
    ) dut (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .req         (req),
        .value       (value),
        .grant       (grant),
        .owner       (owner),
        .disp_value  (disp_value),
        .disp_blank  (disp_blank),
        .sat         (sat)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode  = M_IDLE;
        m_owner = 0;
        m_last  = NUM_REQ - 1;
        m_bcnt  = 0;
        m_hcnt  = 0;
        m_edges = 0;
        e_grant = '0;
        e_blank = 1'b1;
        e_disp  = 16'd0;
        e_sat   = 1'b0;
    endtask

    // Requester 0 first; otherwise the first ordinary requester found walking
    // upward from the one after 'after', wrapping around.
    function automatic int pick(input logic [2:0] r, input int after);
        if (r[0]) return 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (after + k) % NUM_REQ;
            if (c != 0 && r[c]) return c;
        end
        return -1;
    endfunction

    // Advance the model across one rising edge using the inputs present now.
    task automatic model_step();
        logic [2:0]  r;
        logic [2:0]  others;
        logic [15:0] v;
        bit          tick;
        int          old_b, old_h;
        r    = 3'(req);
        tick = ((m_edges % TICK_DIV) == TICK_DIV - 1);
        case (m_mode)
            M_IDLE: begin
                if (r != 0) begin
                    m_owner = pick(r, m_last);
                    m_bcnt  = 0;
                    m_mode  = M_BLANK;
                end
            end
            M_BLANK: begin
                old_b = m_bcnt;
                if (tick && m_bcnt < BLANK_MS) m_bcnt++;
                if (!r[m_owner]) m_mode = M_IDLE;
                else if (r[0] && m_owner != 0) begin
                    m_owner = 0;
                    m_bcnt  = 0;
                end else if (old_b >= BLANK_MS) begin
                    m_mode = M_OWNED;
                    m_hcnt = 0;
                    m_last = m_owner;
                end
            end
            default: begin
                old_h = m_hcnt;
                if (tick && m_hcnt < MIN_HOLD_MS) m_hcnt++;
                others = r & ~(3'b001 << m_owner);
                if (!r[m_owner]) begin
                    if (r != 0) begin
                        m_owner = pick(r, m_last);
                        m_bcnt  = 0;
                        m_mode  = M_BLANK;
                    end else m_mode = M_IDLE;
                end else if (r[0] && m_owner != 0) begin
                    m_owner = 0;
                    m_bcnt  = 0;
                    m_mode  = M_BLANK;
                end else if (others != 0 && old_h == MIN_HOLD_MS) begin
                    m_owner = pick(others, m_last);
                    m_bcnt  = 0;
                    m_mode  = M_BLANK;
                end
            end
        endcase
        m_edges++;
        if (m_mode == M_OWNED) begin
            v       = value[16*m_owner +: 16];
            e_grant = 3'b001 << m_owner;
            e_blank = 1'b0;
            e_disp  = (v > 16'd9999) ? 16'd9999 : v;
            e_sat   = (v > 16'd9999);
        end else begin
            e_grant = '0;
            e_blank = 1'b1;
            e_disp  = 16'd0;
            e_sat   = 1'b0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock_100Mhz);
        #1;
        chk("grant",      32'(grant),      32'(e_grant));
        chk("owner",      32'(owner),      32'(m_owner));
        chk("disp_value", 32'(disp_value), 32'(e_disp));
        chk("disp_blank", 32'(disp_blank), 32'(e_blank));
        chk("sat",        32'(sat),        32'(e_sat));
    endtask

    task automatic wait_grant(input logic [2:0] exp, input int budget, input string tag);
        int n;
        n = 0;
        while (grant !== exp && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(grant), 32'(exp));
    endtask

    initial begin : main
        int   rb;
        logic g_seen;
        logic dark_ok;

        // Reset state
        m_reset();
        @(posedge clock_100Mhz);
        @(posedge clock_100Mhz);
        #1;
        chk("rst_grant", 32'(grant),      32'd0);
        chk("rst_owner", 32'(owner),      32'd0);
        chk("rst_value", 32'(disp_value), 32'd0);
        chk("rst_blank", 32'(disp_blank), 32'd1);
        chk("rst_sat",   32'(sat),        32'd0);
        reset = 1'b0;
        m_reset();
        repeat (3) cycle();

        // Single requester keeps the display indefinitely
        value[47:32] = 16'd1234;
        req = 3'b100;
        wait_grant(3'b100, 20, "single_grant");
        chk("single_value", 32'(disp_value), 32'd1234);
        repeat (100) cycle();
        chk("single_hold", 32'(grant), 32'b100);
        req = 3'b000;
        cycle();
        chk("single_release", 32'(grant),      32'd0);
        chk("single_dark",    32'(disp_blank), 32'd1);
        repeat (2) cycle();

        // Round-robin between requesters 1 and 2
        value[31:16] = 16'd111;
        value[47:32] = 16'd222;
        req = 3'b110;
        wait_grant(3'b010, 20, "rr_first");
        chk("rr_first_val", 32'(disp_value), 32'd111);
        wait_grant(3'b000, 30, "rr_gap");
        wait_grant(3'b100, 20, "rr_second");
        chk("rr_owner2", 32'(owner), 32'd2);

        // Requester 0 preempts owner 2 while its hold has just started
        value[15:0] = 16'd7;
        req = 3'b111;
        cycle();
        chk("preempt_gap", 32'(grant), 32'd0);
        wait_grant(3'b001, 20, "preempt_grant");
        repeat (40) cycle();
        chk("preempt_keep", 32'(grant), 32'b001);
        req = 3'b110;
        wait_grant(3'b010, 20, "after_preempt");

        // Saturation of the displayed value
        req = 3'b000;
        repeat (2) cycle();
        value[31:16] = 16'd12000;
        req = 3'b010;
        wait_grant(3'b010, 20, "sat_grant");
        chk("sat_value", 32'(disp_value), 32'd9999);
        chk("sat_flag",  32'(sat),        32'd1);
        value[31:16] = 16'd42;
        cycle();
        chk("unsat_value", 32'(disp_value), 32'd42);
        chk("unsat_flag",  32'(sat),        32'd0);

        // Request withdrawn during the blanking gap
        req = 3'b000;
        repeat (3) cycle();
        g_seen  = 1'b0;
        dark_ok = 1'b1;
        req = 3'b010;
        cycle();
        g_seen  = g_seen | (|grant);
        dark_ok = dark_ok & disp_blank;
        cycle();
        g_seen  = g_seen | (|grant);
        dark_ok = dark_ok & disp_blank;
        req = 3'b000;
        for (int i = 0; i < 10; i++) begin
            cycle();
            g_seen  = g_seen | (|grant);
            dark_ok = dark_ok & disp_blank;
        end
        chk("blank_rel_grant", 32'(g_seen),  32'd0);
        chk("blank_rel_dark",  32'(dark_ok), 32'd1);

        // Randomized requests and values
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rb = int'($urandom_range(1, NUM_REQ - 1));
                req[rb] = ~req[rb];
            end
            if ($urandom_range(0, 31) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 15) == 0) begin
                rb = int'($urandom_range(0, NUM_REQ - 1));
                if ($urandom_range(0, 3) == 0)
                    value[16*rb +: 16] = 16'($urandom_range(10000, 65535));
                else
                    value[16*rb +: 16] = 16'($urandom_range(0, 9999));
            end
            cycle();
        end

        // Asynchronous reset while a requester owns the display
        req = 3'b000;
        repeat (3) cycle();
        value[31:16] = 16'd500;
        req = 3'b010;
        wait_grant(3'b010, 40, "rst_pre_grant");
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_grant", 32'(grant),      32'd0);
        chk("rst_mid_blank", 32'(disp_blank), 32'd1);
        chk("rst_mid_value", 32'(disp_value), 32'd0);
        @(posedge clock_100Mhz);
        #1;
        reset = 1'b0;
        m_reset();
        wait_grant(3'b010, 10, "rst_regrant");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
